// File: rtl/csr_access_arbiter.sv
// Shares one CSR port between core and debug with an atomic read-then-optional-write: grant at T, done at T+2 (read) or T+3 (RMW).
// No backpressure on the CSR side; requesters hold req while busy, debug has priority unless the core has starved STARVE_LIMIT cycles.
module csr_access_arbiter #(
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      core_req_i,
    input  logic [CSR_ADDR_WIDTH-1:0] core_addr_i,
    input  logic [1:0]                core_op_i,
    input  logic [DATA_WIDTH-1:0]     core_wdata_i,
    output logic                      core_gnt_o,
    output logic                      core_done_o,
    output logic [DATA_WIDTH-1:0]     core_rdata_o,
    output logic                      core_err_o,
    input  logic                      dbg_req_i,
    input  logic [CSR_ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [1:0]                dbg_op_i,
    input  logic [DATA_WIDTH-1:0]     dbg_wdata_i,
    output logic                      dbg_gnt_o,
    output logic                      dbg_done_o,
    output logic [DATA_WIDTH-1:0]     dbg_rdata_o,
    output logic                      dbg_err_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic                      csr_read_en_o,
    input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
    output logic                      csr_write_en_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t                    r_state;
    logic                      r_owner;
    logic [CSR_ADDR_WIDTH-1:0] r_addr;
    logic [1:0]                r_op;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_old;
    logic [7:0]                r_starve;
    logic                      r_read_en;
    logic                      r_write_en;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_addr;
    logic [DATA_WIDTH-1:0]     r_csr_wdata;
    logic                      r_core_done;
    logic                      r_dbg_done;
    logic [DATA_WIDTH-1:0]     r_core_rdata;
    logic [DATA_WIDTH-1:0]     r_dbg_rdata;
    logic                      r_core_err;
    logic                      r_dbg_err;

    logic                      w_idle;
    logic                      w_core_win;
    logic                      w_dbg_win;
    logic                      w_ro;
    logic [DATA_WIDTH-1:0]     w_wdata;

    // Grants are combinational so the pulse lands in the arbitration cycle; held off during reset.
    assign w_idle     = (r_state == S_IDLE);
    assign w_core_win = rst_i & w_idle & core_req_i & (~dbg_req_i | (r_starve == LIMIT));
    assign w_dbg_win  = rst_i & w_idle & dbg_req_i & ~w_core_win;
    assign w_ro       = (r_addr[CSR_ADDR_WIDTH-1 -: 2] == 2'b11);

    always_comb begin
        w_wdata = r_wdata;
        case (r_op)
            OP_WRITE: w_wdata = r_wdata;
            OP_SET:   w_wdata = csr_rdata_i | r_wdata;
            OP_CLEAR: w_wdata = csr_rdata_i & ~r_wdata;
            default:  w_wdata = r_wdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_op         <= OP_READ;
            r_wdata      <= '0;
            r_old        <= '0;
            r_starve     <= '0;
            r_read_en    <= 1'b0;
            r_write_en   <= 1'b0;
            r_csr_addr   <= '0;
            r_csr_wdata  <= '0;
            r_core_done  <= 1'b0;
            r_dbg_done   <= 1'b0;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
            r_core_err   <= 1'b0;
            r_dbg_err    <= 1'b0;
        end else begin
            r_read_en   <= 1'b0;
            r_write_en  <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_core_done <= 1'b0;
            r_dbg_done  <= 1'b0;

            if (!core_req_i || w_core_win)
                r_starve <= '0;
            else if (r_starve != LIMIT)
                r_starve <= r_starve + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_core_win || w_dbg_win) begin
                        r_owner    <= w_dbg_win;
                        r_addr     <= w_dbg_win ? dbg_addr_i  : core_addr_i;
                        r_op       <= w_dbg_win ? dbg_op_i    : core_op_i;
                        r_wdata    <= w_dbg_win ? dbg_wdata_i : core_wdata_i;
                        r_read_en  <= 1'b1;
                        r_csr_addr <= w_dbg_win ? dbg_addr_i  : core_addr_i;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_old <= csr_rdata_i;
                    if (r_op == OP_READ || w_ro) begin
                        // Read-only space: the write is dropped and reported, the old value still returned.
                        r_state     <= S_DONE;
                        r_core_done <= ~r_owner;
                        r_dbg_done  <= r_owner;
                        if (r_owner) begin
                            r_dbg_rdata <= csr_rdata_i;
                            r_dbg_err   <= (r_op != OP_READ);
                        end else begin
                            r_core_rdata <= csr_rdata_i;
                            r_core_err   <= (r_op != OP_READ);
                        end
                    end else begin
                        r_state     <= S_WRITE;
                        r_write_en  <= 1'b1;
                        r_csr_addr  <= r_addr;
                        r_csr_wdata <= w_wdata;
                    end
                end
                S_WRITE: begin
                    r_state     <= S_DONE;
                    r_core_done <= ~r_owner;
                    r_dbg_done  <= r_owner;
                    if (r_owner) begin
                        r_dbg_rdata <= r_old;
                        r_dbg_err   <= 1'b0;
                    end else begin
                        r_core_rdata <= r_old;
                        r_core_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_gnt_o     = w_core_win;
    assign dbg_gnt_o      = w_dbg_win;
    assign core_done_o    = r_core_done;
    assign dbg_done_o     = r_dbg_done;
    assign core_rdata_o   = r_core_rdata;
    assign dbg_rdata_o    = r_dbg_rdata;
    assign core_err_o     = r_core_err;
    assign dbg_err_o      = r_dbg_err;
    assign csr_addr_o     = r_csr_addr;
    assign csr_read_en_o  = r_read_en;
    assign csr_write_en_o = r_write_en;
    assign csr_wdata_o    = r_csr_wdata;
    assign busy_o         = ~w_idle;
endmodule
